tls_multi: RTL

- Parametrised multi-direction intersection traffic-light controller; next-generation single-signal G/Y/R sequencer.
- Sequences NUM_DIR approaches in round-robin: GREEN -> YELLOW -> ALL-RED clearance, then the next approach.
- Adds runtime-loadable durations of width CW, an all-red clearance phase, a per-cycle completion pulse, and emergency preemption toward a selected approach.
- Sits between the intersection configuration registers and the lamp drivers.

---
 rtl/tls_multi.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tls_multi.sv
// tls_multi -- round-robin traffic-light sequencer for NUM_DIR approaches.
//
// Each approach gets GREEN -> YELLOW -> ALL-RED clearance in turn, then the
// next approach is served. The three durations are loaded at reset with the
// G_DEF/Y_DEF/AR_DEF defaults and can be reloaded at runtime with `set`.
// An emergency preempt request steers the sequence toward one approach and
// holds its green for as long as the request stays high.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   set              load gin/yin/arin, restart at approach 0 GREEN
//   stop             freeze phase, approach and counter
//   jump             abort the current phase, go to ALL-RED of this approach
//   preempt          level request for emergency green
//   preempt_dir      approach to grant while preempt is high
//   gin, yin, arin   green / yellow / all-red durations in cycles
//   gout, yout       one-hot green / yellow lamp per approach
//   rout             red lamp per approach (neither green nor yellow)
//   dir_o            approach currently being served
//   phase_o          0 = GREEN, 1 = YELLOW, 2 = ALL-RED
//   cycle_done       one-cycle pulse at the end of the full round
//
// Control priority each cycle: reset > set > jump > stop > preempt > normal.

module tls_multi #(
  parameter int NUM_DIR = 2,
  parameter int CW      = 6,
  parameter int G_DEF   = 8,
  parameter int Y_DEF   = 3,
  parameter int AR_DEF  = 1,
  localparam int DW     = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set,
  input  logic               stop,
  input  logic               jump,
  input  logic               preempt,
  input  logic [DW-1:0]      preempt_dir,
  input  logic [CW-1:0]      gin,
  input  logic [CW-1:0]      yin,
  input  logic [CW-1:0]      arin,
  output logic [NUM_DIR-1:0] gout,
  output logic [NUM_DIR-1:0] yout,
  output logic [NUM_DIR-1:0] rout,
  output logic [DW-1:0]      dir_o,
  output logic [1:0]         phase_o,
  output logic               cycle_done
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_e;

  localparam logic [DW-1:0] LAST_DIR  = DW'(NUM_DIR - 1);
  localparam logic [DW-1:0] DIR_ONE   = DW'(1);
  localparam logic [DW:0]   NUM_DIR_W = (DW + 1)'(NUM_DIR);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  phase_e        phase_q, phase_d;
  logic [DW-1:0] dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] g_dur_q, g_dur_d;
  logic [CW-1:0] y_dur_q, y_dur_d;
  logic [CW-1:0] ar_dur_q, ar_dur_d;

  logic [CW-1:0] cur_dur;
  logic [CW-1:0] last_cnt;
  logic          phase_end;
  logic          pre_valid;
  logic [DW-1:0] next_dir;
  logic [NUM_DIR-1:0] dir_onehot;

  // Duration of the phase we are in. A stored 0 behaves like 1, so the
  // final count value is 0 in both cases; this keeps every phase >= 1 cycle.
  always_comb begin
    cur_dur = ar_dur_q;
    case (phase_q)
      PH_GREEN:  cur_dur = g_dur_q;
      PH_YELLOW: cur_dur = y_dur_q;
      default:   cur_dur = ar_dur_q;
    endcase
  end

  assign last_cnt  = (cur_dur == '0) ? '0 : (cur_dur - CNT_ONE);
  assign phase_end = (cnt_q == last_cnt);

  // A request naming a non-existent approach is treated as no request.
  assign pre_valid = preempt && ({1'b0, preempt_dir} < NUM_DIR_W);

  assign next_dir = pre_valid ? preempt_dir
                  : ((dir_q == LAST_DIR) ? '0 : (dir_q + DIR_ONE));

  always_comb begin
    phase_d  = phase_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    g_dur_d  = g_dur_q;
    y_dur_d  = y_dur_q;
    ar_dur_d = ar_dur_q;

    if (set) begin
      g_dur_d  = gin;
      y_dur_d  = yin;
      ar_dur_d = arin;
      phase_d  = PH_GREEN;
      dir_d    = '0;
      cnt_d    = '0;
    end else if (jump) begin
      // Also restarts clearance when already in ALL-RED.
      phase_d = PH_ALLRED;
      cnt_d   = '0;
    end else if (stop) begin
      // everything held
    end else if ((phase_q == PH_GREEN) && pre_valid && (preempt_dir != dir_q)) begin
      // Emergency: cut this green short with no minimum; yellow and
      // clearance still run in full before the granted green.
      phase_d = PH_YELLOW;
      cnt_d   = '0;
    end else if ((phase_q == PH_GREEN) && pre_valid) begin
      // Granted approach keeps green; count resumes after release.
    end else if (phase_end) begin
      cnt_d = '0;
      case (phase_q)
        PH_GREEN:  phase_d = PH_YELLOW;
        PH_YELLOW: phase_d = PH_ALLRED;
        default: begin
          phase_d = PH_GREEN;
          dir_d   = next_dir;
        end
      endcase
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= PH_GREEN;
      dir_q    <= '0;
      cnt_q    <= '0;
      g_dur_q  <= CW'(G_DEF);
      y_dur_q  <= CW'(Y_DEF);
      ar_dur_q <= CW'(AR_DEF);
    end else begin
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      g_dur_q  <= g_dur_d;
      y_dur_q  <= y_dur_d;
      ar_dur_q <= ar_dur_d;
    end
  end

  // Lamp decode straight from registered state.
  always_comb begin
    for (int i = 0; i < NUM_DIR; i++) begin
      dir_onehot[i] = (dir_q == DW'(i));
    end
  end

  assign gout    = (phase_q == PH_GREEN)  ? dir_onehot : '0;
  assign yout    = (phase_q == PH_YELLOW) ? dir_onehot : '0;
  assign rout    = ~(gout | yout);
  assign dir_o   = dir_q;
  assign phase_o = phase_q;

  // End of the last approach's clearance closes the round, whichever
  // approach is served next.
  assign cycle_done = (phase_q == PH_ALLRED) && (dir_q == LAST_DIR) && phase_end
                      && !reset && !set && !jump && !stop;

endmodule
